// File: rtl/instruction_fetch_pkg.sv
// Shared processor constants: fetch FSM encoding, fault codes, the NOP word
// and the PC-target helpers used by the fetch stage.
package instruction_fetch_pkg;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    localparam logic [1:0]  FAULT_NONE       = 2'd0;
    localparam logic [1:0]  FAULT_MISALIGNED = 2'd1;
    localparam logic [1:0]  FAULT_RANGE      = 2'd2;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    // PC-relative branch: word offset sign-extended and scaled by 4.
    function automatic logic [31:0] branch_target(input logic [31:0] pc_plus4,
                                                  input logic [15:0] imm);
        return pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
    endfunction

    // Pseudo-direct jump: keep the top nibble of the sequential PC.
    function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                                input logic [25:0] index);
        return {pc_plus4[31:28], index, 2'b00};
    endfunction

    // True when the last byte of the word at addr lies past the memory end.
    // Evaluated in 33 bits so addresses near 2^32 do not wrap into range.
    function automatic logic beyond_end(input logic [31:0] addr,
                                        input int unsigned mem_bytes);
        return (({1'b0, addr} + 33'd3) >= 33'(mem_bytes));
    endfunction

endpackage

// File: rtl/instruction_fetch_memory.sv
// Read-only byte-addressed instruction store with a combinational big-endian
// word read. Contents are loaded from outside through
// imemory.storage.bytes; the fetch logic never writes it.
module instruction_memory
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned IMEM_BYTES = 1024
) (
    input  logic [31:0] addr,
    output logic [31:0] rdata
);

    localparam int unsigned AW = (IMEM_BYTES > 8) ? $clog2(IMEM_BYTES) : 3;

    if (1'b1) begin : storage
        logic [7:0] bytes [IMEM_BYTES];
    end

    logic [AW-1:0] base_s;
    logic          in_range_s;

    // Word-aligned byte index and range guard for the requested address.
    always_comb begin
        base_s     = {addr[AW-1:2], 2'b00};
        in_range_s = !beyond_end(addr, IMEM_BYTES);
    end

    // Big-endian assembly: lowest address supplies the most significant byte.
    always_comb begin
        if (in_range_s) begin
            rdata = {storage.bytes[base_s],
                     storage.bytes[base_s + AW'(1)],
                     storage.bytes[base_s + AW'(2)],
                     storage.bytes[base_s + AW'(3)]};
        end else begin
            rdata = NOP_INSTR;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, next-PC selection (jr > jump >
// branch > sequential), target fault checking, RUN/HALT FSM and a retired
// instruction counter. Reset is synchronous and active-high.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_imm,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jump_reg,
    input  logic [31:0] jr_target,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        halted,
    output logic [1:0]  fault,
    output logic [31:0] fetch_count
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  fetch_count_q, fetch_count_d;
    logic [1:0]   fault_q, fault_d;

    logic [31:0]  pc_plus4_s;
    logic [31:0]  next_pc_s;
    logic         misaligned_s;
    logic         out_of_range_s;
    logic         advance_s;
    logic [31:0]  mem_word_s;

    instruction_memory #(
        .IMEM_BYTES (IMEM_BYTES)
    ) imemory (
        .addr  (pc_q),
        .rdata (mem_word_s)
    );

    // Candidate next PC: only the winning redirect is ever fault-checked.
    always_comb begin
        pc_plus4_s = pc_q + 32'd4;
        if (jump_reg) begin
            next_pc_s = jr_target;
        end else if (jump) begin
            next_pc_s = jump_target(pc_plus4_s, jump_index);
        end else if (branch_taken) begin
            next_pc_s = branch_target(pc_plus4_s, branch_imm);
        end else begin
            next_pc_s = pc_plus4_s;
        end
        misaligned_s   = (next_pc_s[1:0] != 2'b00);
        out_of_range_s = beyond_end(next_pc_s, IMEM_BYTES);
        advance_s      = (state_q == ST_RUN) && !stall;
    end

    // Next-state logic: a fault on an advancing cycle latches HALT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (advance_s && (misaligned_s || out_of_range_s)) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    // PC, counter and fault code updates; faulting targets are never loaded.
    always_comb begin
        pc_d          = pc_q;
        fetch_count_d = fetch_count_q;
        fault_d       = fault_q;
        if (advance_s) begin
            fetch_count_d = fetch_count_q + 32'd1;
            if (misaligned_s) begin
                fault_d = FAULT_MISALIGNED;
            end else if (out_of_range_s) begin
                fault_d = FAULT_RANGE;
            end else begin
                pc_d = next_pc_s;
            end
        end else begin
            pc_d = pc_q;
        end
    end

    // State register with synchronous reset taking precedence over stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            fetch_count_q <= 32'd0;
            fault_q       <= FAULT_NONE;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_count_q <= fetch_count_d;
            fault_q       <= fault_d;
        end
    end

    // Output decode: instruction is squashed to NOP while halted.
    always_comb begin
        pc          = pc_q;
        pc_plus4    = pc_plus4_s;
        fetch_count = fetch_count_q;
        fault       = fault_q;
        halted      = (state_q == ST_HALT);
        if (state_q == ST_HALT) begin
            instr = NOP_INSTR;
        end else begin
            instr = mem_word_s;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by
// randomized control traffic, all compared against a behavioural model.
module tb_instruction_fetch;

    localparam int MEMB = 1024;

    logic        clk = 1'b0;
    logic        reset, stall, branch_taken, jump, jump_reg;
    logic [15:0] branch_imm;
    logic [25:0] jump_index;
    logic [31:0] jr_target;
    logic [31:0] instr, pc, pc_plus4, fetch_count;
    logic        halted;
    logic [1:0]  fault;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem [MEMB];
    logic [31:0] m_pc, m_cnt;
    logic        m_halt;
    logic [1:0]  m_fault;

    instruction_fetch #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_BYTES (MEMB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_imm   (branch_imm),
        .jump         (jump),
        .jump_index   (jump_index),
        .jump_reg     (jump_reg),
        .jr_target    (jr_target),
        .instr        (instr),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .halted       (halted),
        .fault        (fault),
        .fetch_count  (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_instr();
        int a;
        if (m_halt) return 32'h0;
        a = int'(m_pc);
        return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
    endfunction

    // One clock: drive at negedge, advance the model, compare after posedge.
    task automatic step(input logic rst, input logic st, input logic br, input logic [15:0] imm,
                        input logic jp, input logic [25:0] idx, input logic jr, input logic [31:0] jt);
        longint tgt;
        longint p4;
        @(negedge clk);
        reset = rst; stall = st; branch_taken = br; branch_imm = imm;
        jump = jp; jump_index = idx; jump_reg = jr; jr_target = jt;
        p4 = (longint'(m_pc) + 4) % 64'h1_0000_0000;
        if (rst) begin
            m_pc = 32'h0; m_cnt = 32'h0; m_halt = 1'b0; m_fault = 2'd0;
        end else if (!st && !m_halt) begin
            m_cnt = m_cnt + 32'd1;
            if (jr)       tgt = longint'(jt);
            else if (jp)  tgt = (p4 / 64'h1000_0000) * 64'h1000_0000 + longint'(idx) * 4;
            else if (br)  tgt = (p4 + longint'($signed(imm)) * 4) % 64'h1_0000_0000;
            else          tgt = p4;
            if (tgt < 0) tgt = tgt + 64'h1_0000_0000;
            if (tgt % 4 != 0) begin
                m_halt = 1'b1; m_fault = 2'd1;
            end else if (tgt + 3 >= MEMB) begin
                m_halt = 1'b1; m_fault = 2'd2;
            end else begin
                m_pc = 32'(tgt);
            end
        end
        @(posedge clk);
        #1;
        check_val("pc", pc, m_pc);
        check_val("pc_plus4", pc_plus4, m_pc + 32'd4);
        check_val("fetch_count", fetch_count, m_cnt);
        check_val("halted", {31'd0, halted}, {31'd0, m_halt});
        check_val("fault", {30'd0, fault}, {30'd0, m_fault});
        check_val("instr", instr, model_instr());
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    endtask

    task automatic go();
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    endtask

    initial begin
        logic        r_rst, r_st, r_br, r_jp, r_jr;
        logic [15:0] r_imm;
        logic [25:0] r_idx;
        logic [31:0] r_jt;

        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_imm = 16'h0;
        jump = 1'b0; jump_index = 26'h0; jump_reg = 1'b0; jr_target = 32'h0;
        m_pc = 32'h0; m_cnt = 32'h0; m_halt = 1'b0; m_fault = 2'd0;
        for (int i = 0; i < MEMB; i++) begin
            mem[i] = 8'($urandom);
            dut.imemory.storage.bytes[i] = mem[i];
        end

        // Reset state, with stall asserted to show reset wins.
        step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        check_val("rst_pc", pc, 32'h0);
        check_val("rst_count", fetch_count, 32'h0);
        check_val("rst_instr", instr, {mem[0], mem[1], mem[2], mem[3]});

        // Sequential fetch: pc walks 0,4,8,12; four retired.
        go(); go(); go();
        check_val("seq_pc12", pc, 32'h0000_000C);
        go();
        check_val("seq_count4", fetch_count, 32'd4);

        // Stall holds pc and counter for three cycles at pc=12.
        do_reset(); go(); go(); go();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 16'h0004, 1'b0, 26'h0, 1'b0, 32'h0);
        check_val("stall_pc", pc, 32'h0000_000C);
        check_val("stall_count", fetch_count, 32'd3);
        go();
        check_val("stall_release_pc", pc, 32'h0000_0010);

        // Backward branch from pc=8.
        do_reset(); go(); go();
        step(1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b0, 26'h0, 1'b0, 32'h0);
        check_val("branch_back_pc", pc, 32'h0000_0004);

        // Jump beats branch at pc=0x10.
        do_reset(); go(); go(); go(); go();
        step(1'b0, 1'b0, 1'b1, 16'h0100, 1'b1, 26'h20, 1'b0, 32'h0);
        check_val("jump_pri_pc", pc, 32'h0000_0080);

        // Misaligned register target halts; halt is sticky until reset.
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h0000_0006);
        check_val("jr_mis_fault", {30'd0, fault}, 32'd1);
        check_val("jr_mis_halted", {31'd0, halted}, 32'd1);
        check_val("jr_mis_pc", pc, 32'h0000_0080);
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 26'h4, 1'b0, 32'h0);
        go();
        check_val("halt_instr", instr, 32'h0);
        check_val("halt_pc", pc, 32'h0000_0080);
        do_reset();
        check_val("halt_exit_pc", pc, 32'h0);

        // Fall off the end of memory from the last word.
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 26'hFF, 1'b0, 32'h0);
        check_val("last_word_pc", pc, 32'h0000_03FC);
        go();
        check_val("range_fault", {30'd0, fault}, 32'd2);
        check_val("range_pc", pc, 32'h0000_03FC);
        do_reset();

        // Randomized control traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            r_rst = ($urandom_range(0, 49) == 0) || (m_halt && $urandom_range(0, 7) == 0);
            r_st  = ($urandom_range(0, 5) == 0);
            r_br  = ($urandom_range(0, 4) == 0);
            r_jp  = ($urandom_range(0, 7) == 0);
            r_jr  = ($urandom_range(0, 9) == 0);
            r_imm = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 31))
                                                : 16'hFFFF - 16'($urandom_range(0, 31));
            r_idx = 26'($urandom_range(0, 300));
            r_jt  = 32'($urandom_range(0, 1100));
            if ($urandom_range(0, 3) != 0) r_jt = r_jt & 32'hFFFF_FFFC;
            step(r_rst, r_st, r_br, r_imm, r_jp, r_idx, r_jr, r_jt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-002 SHALL have parameter IMEM_BYTES, default 1024, meaning the instruction memory size in bytes (multiple of 4).
REQ-003 SHALL have port clk  input  1  the single processor clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port stall  input  1  hold the PC and all state this cycle.
REQ-006 SHALL have port branch_taken  input  1  take the PC-relative branch.
REQ-007 SHALL have port branch_imm  input  16  raw branch immediate from instr[15:0].
REQ-008 SHALL have port jump  input  1  J/JAL taken.
REQ-009 SHALL have port jump_index  input  26  raw jump index from instr[25:0].
REQ-010 SHALL have port jump_reg  input  1  JR/JALR taken.
REQ-011 SHALL have port jr_target  input  32  register-sourced target.
REQ-012 SHALL have port instr  output  32  the instruction at pc.
REQ-013 SHALL have port pc  output  32  the current PC.
REQ-014 SHALL have port pc_plus4  output  32  pc + 4, for the link register and the branch base.
REQ-015 SHALL have port halted  output  1  fetch stopped on a fault.
REQ-016 SHALL have port fault  output  2  fault code: 0 none, 1 misaligned target, 2 out-of-range fetch.
REQ-017 SHALL have port fetch_count  output  32  number of instructions fetched and retired.

Function
REQ-018 SHALL read instr combinationally from the memory at pc, big-endian: bytes[pc] forms bits 31:24 and bytes[pc+3] forms bits 7:0.
REQ-019 SHALL compute pc_plus4 as pc + 4 modulo 2^32.
REQ-020 SHALL form the branch target as pc_plus4 + (sign_extend(branch_imm) << 2).
REQ-021 SHALL form the jump target as {pc_plus4[31:28], jump_index, 2'b00}.
REQ-022 SHALL select next-PC with priority reset > stall > halted > jump_reg > jump > branch_taken > pc_plus4.
REQ-023 SHALL have a two-state FSM: RUN moves to HALT on a fault, and HALT is left only by reset.
REQ-024 SHALL raise fault 1 and enter HALT, with pc unchanged, when the selected next-PC has bits [1:0] != 0.
REQ-025 SHALL raise fault 2 and enter HALT, with pc unchanged, when the selected next-PC + 3 >= IMEM_BYTES.
REQ-026 SHALL drive instr to 32'h0000_0000 (NOP) while in HALT.
REQ-027 SHALL hold pc, FSM state and fetch_count when stall=1, with instr still reflecting pc.
REQ-028 SHALL increment fetch_count by 1 (wrapping) on each cycle where it is in RUN, stall=0 and reset=0.
REQ-029 SHALL evaluate the fault check only on the selected target when several control inputs are asserted together; losing targets are ignored.
REQ-030 SHALL NOT check the fault condition on a cycle where stall=1.

Reset
REQ-031 SHALL on reset set pc=RESET_PC, FSM=RUN, halted=0, fault=0 and fetch_count=0, regardless of stall.
REQ-032 SHALL leave the memory contents unchanged on reset.
REQ-033 SHALL abandon any HALT or pending redirect when reset is asserted mid-operation; the next cycle fetches RESET_PC.

Structure
REQ-034 SHALL take the fault codes, the FSM state encoding and the NOP constant from the shared processor constants package.
REQ-035 SHALL instantiate the memory as sub-module instruction_memory with instance name imemory.
REQ-036 SHALL have instruction_memory hold a byte array, loadable by $readmemb, reached by the hierarchical path imemory.storage.bytes.

Verification
REQ-037 SHALL cover: after reset, 4 sequential cycles -> pc = 0,4,8,12 and fetch_count = 4.
REQ-038 SHALL cover: pc=8, branch_taken=1, branch_imm=16'hFFFE -> next pc = 4.
REQ-039 SHALL cover: pc=32'h10, jump=1 and branch_taken=1, jump_index=26'h20 -> next pc = 32'h80.
REQ-040 SHALL cover: jump_reg=1, jr_target=32'h6 -> halted=1, fault=1, pc held, instr=0 until reset, then pc=0.
REQ-041 SHALL cover: IMEM_BYTES=1024, pc=32'h3FC, no redirect -> fault=2, pc stays at 32'h3FC.
REQ-042 SHALL cover: stall=1 for 3 cycles at pc=12 -> pc=12 and fetch_count unchanged; release -> pc=16.
